// File: rtl/opb_register_bank_ppc2simulink.sv
//-----------------------------------------------------------------------------
// opb_register_bank_ppc2simulink
//
// OPB slave exposing C_NUM_REGS software-writable registers to the Simulink
// fabric. Each register is C_REG_WIDTH bits wide and LSB-aligned in a 32-bit
// word. Writes honour the byte enables. With C_SHADOWED = 1 a write lands in a
// shadow copy and sets a pending bit. A write to the control word at offset
// 0x80 then either commits every pending shadow to live (bit0) or discards
// the shadows by reloading them from live (bit1). With C_SHADOWED = 0 a write
// goes straight to the live value. Every load of a live value raises a
// one-cycle pulse on the matching user_update bit.
//
// Ports:
//   OPB_Clk, OPB_Rst_n   single clock, synchronous active-low reset
//   OPB_ABus [0:31]      byte address, big-endian bit order
//   OPB_BE   [0:3]       byte enables, BE[0] covers value bits 31:24
//   OPB_DBus [0:31]      write data, DBus[0] is value bit 31
//   OPB_RNW              1 = read
//   OPB_select           transfer request
//   OPB_seqAddr          ignored
//   Sl_DBus  [0:31]      read data, zero outside the ack cycle (OR-bus)
//   Sl_xferAck           high for exactly one cycle per accepted transfer
//   Sl_errAck, Sl_retry, Sl_toutSup   tied low
//   user_data_out        live register values, register i at [i*W +: W]
//   user_update          one-cycle pulse per register on a live load
//
// Handshake: a transfer is accepted at the rising edge where OPB_select is
// high, the address lies in the window, the FSM is IDLE and the slave is
// armed. Sl_xferAck is high during the single following cycle, when Sl_DBus
// carries read data. The slave re-arms only after it has seen OPB_select low,
// so a select held high across and beyond the ack cycle is one access.
//-----------------------------------------------------------------------------
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01000900,
    parameter logic [31:0] C_HIGHADDR   = 32'h010009FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          C_NUM_REGS   = 8,
    parameter int          C_REG_WIDTH  = 32,
    parameter int          C_SHADOWED   = 1,
    parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst_n,
    input  logic [0:31]                       OPB_ABus,
    input  logic [0:3]                        OPB_BE,
    input  logic [0:31]                       OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [0:31]                       Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]             user_update
);

    localparam logic [C_REG_WIDTH-1:0] RST_V = C_RESET_VAL[C_REG_WIDTH-1:0];
    localparam logic [31:0] WMASK = (C_REG_WIDTH >= 32) ? 32'hFFFF_FFFF
                                  : ((32'd1 << C_REG_WIDTH) - 32'd1);
    localparam bit SHADOWED = (C_SHADOWED != 0);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t state_r, state_nx;

    logic [C_REG_WIDTH-1:0] live_r   [C_NUM_REGS];
    logic [C_REG_WIDTH-1:0] shadow_r [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]  pending_r;
    logic [31:0]            rd_q;
    logic                   armed_r;

    // Bus fields remapped to little-endian value order: bit 31 = DBus[0].
    logic [31:0] abus;
    logic [31:0] wdata;
    logic [3:0]  be_v;
    logic [31:0] off;
    logic [29:0] word_idx;
    logic [31:0] bmask;
    logic        in_window;
    logic        hit;
    logic        write_en;
    logic        is_ctrl;
    logic        in_width;
    logic        ctrl_wr;
    logic        commit;
    logic        discard;

    logic [C_NUM_REGS-1:0] reg_sel;
    logic [31:0]           cur_val;
    logic [31:0]           rd_data;
    logic [31:0]           wr_val;

    assign abus     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign be_v     = OPB_BE;
    assign off      = abus - C_BASEADDR;
    assign word_idx = off[31:2];

    assign in_window = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign hit       = OPB_select && in_window && (state_r == IDLE) && armed_r;
    assign write_en  = hit && !OPB_RNW;
    assign is_ctrl   = (word_idx == 30'h20);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bmask[8*b +: 8] = {8{be_v[b]}};
        end
    end

    // A write counts only if at least one enabled byte carries valid bits.
    assign in_width = |(bmask & WMASK);

    assign ctrl_wr = write_en && is_ctrl && be_v[0] && SHADOWED;
    assign commit  = ctrl_wr && wdata[0];
    assign discard = ctrl_wr && wdata[1] && !wdata[0];

    // Register decode and read mux; reads see the state before the edge.
    always_comb begin
        reg_sel = '0;
        cur_val = '0;
        rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_idx == 30'(i)) begin
                reg_sel[i] = 1'b1;
                cur_val[C_REG_WIDTH-1:0] = SHADOWED ? shadow_r[i] : live_r[i];
            end
        end
        if (|reg_sel) begin
            rd_data = cur_val;
        end else if (is_ctrl && SHADOWED) begin
            rd_data[C_NUM_REGS-1:0] = pending_r;
        end
    end

    assign wr_val = (cur_val & ~bmask) | (wdata & bmask);

    // FSM: state register
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (hit) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        Sl_xferAck = (state_r == ACK);
    end

    // Datapath: register file, pending mask, read data, update pulses.
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                live_r[i]   <= RST_V;
                shadow_r[i] <= RST_V;
            end
            pending_r   <= '0;
            user_update <= '0;
            rd_q        <= '0;
            armed_r     <= 1'b1;
        end else begin
            user_update <= '0;
            rd_q        <= '0;
            if (hit) begin
                armed_r <= 1'b0;
            end else if (!OPB_select) begin
                armed_r <= 1'b1;
            end
            if (hit && OPB_RNW) begin
                rd_q <= rd_data;
            end
            if (commit || discard) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (commit) begin
                        if (pending_r[i]) begin
                            live_r[i]      <= shadow_r[i];
                            user_update[i] <= 1'b1;
                        end
                    end else begin
                        shadow_r[i] <= live_r[i];
                    end
                end
                pending_r <= '0;
            end
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (write_en && reg_sel[i] && in_width) begin
                    if (SHADOWED) begin
                        shadow_r[i]  <= wr_val[C_REG_WIDTH-1:0];
                        pending_r[i] <= 1'b1;
                    end else begin
                        live_r[i]      <= wr_val[C_REG_WIDTH-1:0];
                        user_update[i] <= 1'b1;
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
            assign user_data_out[g*C_REG_WIDTH +: C_REG_WIDTH] = live_r[g];
        end
    endgenerate

    assign Sl_DBus    = rd_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Bits with no function: seqAddr, sub-word address, value bits above width.
    logic [34:0] unused_bits;
    assign unused_bits = {OPB_seqAddr, off[1:0], wr_val};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
//-----------------------------------------------------------------------------
// Bench for opb_register_bank_ppc2simulink. Two instances share the bus
// address/data/control lines and have separate selects:
//   dut_s : defaults (8 x 32-bit, shadowed)
//   dut_d : direct (unshadowed), 12-bit registers
// The driver pushes the expected Sl_DBus of every transfer into a per-DUT
// queue; a monitor pops and compares whenever Sl_xferAck is seen.
//-----------------------------------------------------------------------------
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01000900;

    logic        clk;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:3]  be_b;
    logic [0:31] dbus_w;
    logic        rnw_b;
    logic        sel_s, sel_d;
    logic        seq_b;

    logic [0:31] dbus_s, dbus_d;
    logic        ack_s, ack_d;
    logic        err_s, err_d, rty_s, rty_d, tout_s, tout_d;
    logic [255:0] ud_s;
    logic [95:0]  ud_d;
    logic [7:0]   upd_s, upd_d;

    logic [31:0] exp_s[$];
    logic [31:0] exp_d[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_xfer_s = 0, n_xfer_d = 0;
    int n_ack_s = 0, n_ack_d = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink dut_s (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_b),
        .OPB_DBus(dbus_w), .OPB_RNW(rnw_b), .OPB_select(sel_s),
        .OPB_seqAddr(seq_b), .Sl_DBus(dbus_s), .Sl_xferAck(ack_s),
        .Sl_errAck(err_s), .Sl_retry(rty_s), .Sl_toutSup(tout_s),
        .user_data_out(ud_s), .user_update(upd_s)
    );

    opb_register_bank_ppc2simulink #(.C_SHADOWED(0), .C_REG_WIDTH(12)) dut_d (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_b),
        .OPB_DBus(dbus_w), .OPB_RNW(rnw_b), .OPB_select(sel_d),
        .OPB_seqAddr(seq_b), .Sl_DBus(dbus_d), .Sl_xferAck(ack_d),
        .Sl_errAck(err_d), .Sl_retry(rty_d), .Sl_toutSup(tout_d),
        .user_data_out(ud_d), .user_update(upd_d)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic prev_ack_s = 1'b0, prev_ack_d = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (ack_s) begin
                n_ack_s++;
                check("ack_s_single_cycle", {31'd0, prev_ack_s}, 32'd0);
                if (exp_s.size() == 0) begin
                    check("ack_s_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rdata_s", dbus_s, exp_s.pop_front());
                end
            end
            if (ack_d) begin
                n_ack_d++;
                check("ack_d_single_cycle", {31'd0, prev_ack_d}, 32'd0);
                if (exp_d.size() == 0) begin
                    check("ack_d_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rdata_d", dbus_d, exp_d.pop_front());
                end
            end
            prev_ack_s = ack_s;
            prev_ack_d = ack_d;
        end
    end

    // ---------------- driver tasks ----------------
    // One transfer; returns user_update sampled during the ack cycle.
    task automatic xfer(input bit to_d, input logic [31:0] off,
                        input logic [3:0] be, input logic [31:0] data,
                        input bit rnw, input logic [31:0] exp,
                        output logic [7:0] upd);
        @(negedge clk);
        abus   = BASE + off;
        be_b   = be;
        dbus_w = data;
        rnw_b  = rnw;
        if (to_d) begin
            exp_d.push_back(exp);
            n_xfer_d++;
            sel_d = 1'b1;
        end else begin
            exp_s.push_back(exp);
            n_xfer_s++;
            sel_s = 1'b1;
        end
        @(posedge clk);
        #1;
        sel_s = 1'b0;
        sel_d = 1'b0;
        @(negedge clk);
        upd = to_d ? upd_d : upd_s;
    endtask

    task automatic rd(input bit to_d, input logic [31:0] off, input logic [31:0] exp);
        logic [7:0] u;
        xfer(to_d, off, 4'b1111, 32'h0, 1'b1, exp, u);
    endtask

    task automatic wr(input bit to_d, input logic [31:0] off, input logic [3:0] be,
                      input logic [31:0] data, output logic [7:0] upd);
        xfer(to_d, off, be, data, 1'b0, 32'h0, upd);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [7:0] u;
        int acks, upds;
        rst_n = 1'b0; abus = '0; be_b = '0; dbus_w = '0; rnw_b = 1'b1;
        sel_s = 1'b0; sel_d = 1'b0; seq_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack_s", {31'd0, ack_s}, 32'd0);
        check("rst_dbus_s", dbus_s, 32'd0);
        check("rst_upd_s", {24'd0, upd_s}, 32'd0);
        check("rst_ud_s_lo", ud_s[31:0], 32'd0);
        check("rst_ties", {29'd0, err_s, rty_s, tout_s}, 32'd0);
        rst_n = 1'b1;

        // Reset contents of all shadowed registers
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 32'(4*i), 4'b1111, 32'h0, 1'b1, 32'h0, u);
            check("rd_reset_upd", {24'd0, u}, 32'd0);
        end

        // Partial byte write to register 1, then commit
        wr(1'b0, 32'h04, 4'b0011, 32'hDEADBEEF, u);
        check("shadow_wr_upd", {24'd0, u}, 32'd0);
        check("shadow_wr_live", ud_s[63:32], 32'd0);
        rd(1'b0, 32'h04, 32'h0000BEEF);
        rd(1'b0, 32'h80, 32'h00000002);
        wr(1'b0, 32'h80, 4'b1111, 32'h1, u);
        check("commit_upd", {24'd0, u}, 32'h02);
        check("commit_live", ud_s[63:32], 32'h0000BEEF);
        rd(1'b0, 32'h80, 32'h0);

        // Discard pending writes to registers 2 and 5
        wr(1'b0, 32'h08, 4'b1111, 32'h22222222, u);
        wr(1'b0, 32'h14, 4'b1111, 32'h55555555, u);
        rd(1'b0, 32'h80, 32'h00000024);
        wr(1'b0, 32'h80, 4'b1111, 32'h2, u);
        check("discard_upd", {24'd0, u}, 32'd0);
        check("discard_live2", ud_s[95:64], 32'd0);
        rd(1'b0, 32'h08, 32'h0);
        rd(1'b0, 32'h14, 32'h0);
        rd(1'b0, 32'h80, 32'h0);

        // Commit and discard together: commit wins
        wr(1'b0, 32'h08, 4'b1111, 32'h12345678, u);
        wr(1'b0, 32'h80, 4'b1111, 32'h3, u);
        check("commit3_upd", {24'd0, u}, 32'h04);
        check("commit3_live2", ud_s[95:64], 32'h12345678);
        rd(1'b0, 32'h08, 32'h12345678);
        rd(1'b0, 32'h04, 32'h0000BEEF);

        // Unshadowed, 12-bit instance
        wr(1'b1, 32'h0C, 4'b1111, 32'hFFFFFFFF, u);
        check("direct_upd", {24'd0, u}, 32'h08);
        check("direct_live3", {20'd0, ud_d[36 +: 12]}, 32'h00000FFF);
        rd(1'b1, 32'h0C, 32'h00000FFF);
        rd(1'b1, 32'h80, 32'h0);
        wr(1'b1, 32'h80, 4'b1111, 32'h1, u);
        check("direct_ctrl_upd", {24'd0, u}, 32'd0);

        // Select held high for 4 cycles: one access only
        @(negedge clk);
        abus = BASE + 32'h18; be_b = 4'b1111; dbus_w = 32'h00000123; rnw_b = 1'b0;
        exp_d.push_back(32'h0);
        n_xfer_d++;
        sel_d = 1'b1;
        acks = 0; upds = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            if (k == 3) begin
                #1;
                sel_d = 1'b0;
            end
            @(negedge clk);
            acks += int'(ack_d);
            upds += int'(upd_d[6]);
        end
        check("hold_acks", 32'(acks), 32'd1);
        check("hold_upds", 32'(upds), 32'd1);
        rd(1'b1, 32'h18, 32'h00000123);

        // Unmapped in-window offset
        wr(1'b0, 32'hF0, 4'b1111, 32'hFFFFFFFF, u);
        check("unmapped_upd", {24'd0, u}, 32'd0);
        rd(1'b0, 32'hF0, 32'h0);
        rd(1'b0, 32'h80, 32'h0);
        check("unmapped_live1", ud_s[63:32], 32'h0000BEEF);
        check("unmapped_live2", ud_s[95:64], 32'h12345678);

        // Reset asserted in the cycle a write is sampled
        @(negedge clk);
        abus = BASE; be_b = 4'b1111; dbus_w = 32'h00000ABC; rnw_b = 1'b0;
        sel_d = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sel_d = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstwr_ack_d", {31'd0, ack_d}, 32'd0);
        check("rstwr_upd_d", {24'd0, upd_d}, 32'd0);
        check("rstwr_live0", {20'd0, ud_d[11:0]}, 32'd0);
        check("rstwr_live_s2", ud_s[95:64], 32'd0);
        rd(1'b1, 32'h00, 32'h0);
        rd(1'b0, 32'h08, 32'h0);

        repeat (4) @(negedge clk);
        check("exp_s_drained", 32'(exp_s.size()), 32'd0);
        check("exp_d_drained", 32'(exp_d.size()), 32'd0);
        check("ack_count_s", 32'(n_ack_s), 32'(n_xfer_s));
        check("ack_count_d", 32'(n_ack_d), 32'(n_xfer_d));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
